// File: rtl/inst_encode_pkg.sv
// Shared RV32I definitions: opcode constants, encoding formats and the opcode-to-format map.
package inst_encode_pkg;

    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FmtR,
        FmtI,
        FmtS,
        FmtB,
        FmtU,
        FmtJ
    } fmt_e;

    // Anything not recognised falls back to I type so unknown opcodes still encode.
    function automatic fmt_e opcode_fmt(input logic [6:0] opc);
        fmt_e fmt;
        case (opc)
            OP:          fmt = FmtR;
            STORE:       fmt = FmtS;
            BRANCH:      fmt = FmtB;
            JAL:         fmt = FmtJ;
            LUI, AUIPC:  fmt = FmtU;
            default:     fmt = FmtI;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/inst_encode_fmt.sv
// Combinational field packer: places instruction fields into a 32-bit word and flags
// immediates that do not fit the selected format.
module inst_encode_fmt
    import inst_encode_pkg::*;
(
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [31:0] i_imm,
    output logic [31:0] o_inst,
    output logic        o_err
);

    fmt_e w_fmt;
    logic w_fits11;
    logic w_fits12;
    logic w_fits20;

    assign w_fmt = opcode_fmt(i_opcode);

    // Sign-extension checks: every bit above the field's sign bit must match it.
    assign w_fits11 = (&i_imm[31:11]) | ~(|i_imm[31:11]);
    assign w_fits12 = (&i_imm[31:12]) | ~(|i_imm[31:12]);
    assign w_fits20 = (&i_imm[31:20]) | ~(|i_imm[31:20]);

    always_comb begin
        o_inst = '0;
        o_err  = 1'b0;
        unique case (w_fmt)
            FmtR: begin
                o_inst = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            end
            FmtS: begin
                o_inst = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                o_err  = ~w_fits11;
            end
            FmtB: begin
                o_inst = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3, i_imm[4:1],
                          i_imm[11], i_opcode};
                o_err  = ~w_fits12 | i_imm[0];
            end
            FmtJ: begin
                o_inst = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
                o_err  = ~w_fits20 | i_imm[0];
            end
            FmtU: begin
                o_inst = {i_imm[31:12], i_rd, i_opcode};
                o_err  = |i_imm[11:0];
            end
            default: begin
                o_inst = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                // CSR numbers are unsigned, so SYSTEM only needs the upper bits clear.
                o_err  = (i_opcode == SYSTEM) ? (|i_imm[31:12]) : ~w_fits11;
            end
        endcase
    end

endmodule

// File: rtl/inst_encode.sv
// Streaming RV32I encoder: field packer followed by a two-entry skid buffer, a word-address
// counter and a saturating count of out-of-range words.
module inst_encode
    import inst_encode_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [6:0]          opcode,
    input  logic [4:0]          rd,
    input  logic [4:0]          rs1,
    input  logic [4:0]          rs2,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    input  logic [31:0]         imm,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_inst,
    output logic                out_err,
    output logic [ADDR_W-1:0]   out_addr,
    output logic [ERRCNT_W-1:0] err_count
);

    logic [31:0]         w_inst;
    logic                w_err;
    logic                w_in_hs;
    logic                w_out_hs;

    logic                r_main_full;
    logic [31:0]         r_main_inst;
    logic                r_main_err;
    logic                r_skid_full;
    logic [31:0]         r_skid_inst;
    logic                r_skid_err;
    logic [ADDR_W-1:0]   r_addr;
    logic [ERRCNT_W-1:0] r_err_count;

    inst_encode_fmt u_fmt (
        .i_opcode (opcode),
        .i_rd     (rd),
        .i_rs1    (rs1),
        .i_rs2    (rs2),
        .i_funct3 (funct3),
        .i_funct7 (funct7),
        .i_imm    (imm),
        .o_inst   (w_inst),
        .o_err    (w_err)
    );

    assign w_in_hs  = in_valid & ~r_skid_full;
    assign w_out_hs = r_main_full & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_main_full <= 1'b0;
            r_main_inst <= '0;
            r_main_err  <= 1'b0;
            r_skid_full <= 1'b0;
            r_skid_inst <= '0;
            r_skid_err  <= 1'b0;
            r_addr      <= '0;
            r_err_count <= '0;
        end else begin
            if (w_out_hs) begin
                r_addr <= r_addr + ADDR_W'(1);
                if (r_main_err && !(&r_err_count)) begin
                    r_err_count <= r_err_count + ERRCNT_W'(1);
                end
                // in_ready is low whenever the skid is full, so no input can race the refill.
                if (r_skid_full) begin
                    r_main_inst <= r_skid_inst;
                    r_main_err  <= r_skid_err;
                    r_skid_full <= 1'b0;
                end else if (w_in_hs) begin
                    r_main_inst <= w_inst;
                    r_main_err  <= w_err;
                end else begin
                    r_main_full <= 1'b0;
                end
            end else if (w_in_hs) begin
                if (r_main_full) begin
                    r_skid_inst <= w_inst;
                    r_skid_err  <= w_err;
                    r_skid_full <= 1'b1;
                end else begin
                    r_main_inst <= w_inst;
                    r_main_err  <= w_err;
                    r_main_full <= 1'b1;
                end
            end
        end
    end

    assign in_ready  = ~r_skid_full;
    assign out_valid = r_main_full;
    assign out_inst  = r_main_inst;
    assign out_err   = r_main_err;
    assign out_addr  = r_addr;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_inst_encode.sv
// Bench for inst_encode: directed and random words checked by decoding the output against
// a queue of expected fields with arithmetic range rules.
module tb_inst_encode;

    localparam logic [6:0] LUI_C    = 7'b0110111;
    localparam logic [6:0] AUIPC_C  = 7'b0010111;
    localparam logic [6:0] JAL_C    = 7'b1101111;
    localparam logic [6:0] JALR_C   = 7'b1100111;
    localparam logic [6:0] BRANCH_C = 7'b1100011;
    localparam logic [6:0] LOAD_C   = 7'b0000011;
    localparam logic [6:0] STORE_C  = 7'b0100011;
    localparam logic [6:0] OP_IMM_C = 7'b0010011;
    localparam logic [6:0] OP_C     = 7'b0110011;
    localparam logic [6:0] SYSTEM_C = 7'b1110011;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        has_hex;
        logic [31:0] hex;
    } word_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic [7:0]  out_addr;
    logic [7:0]  err_count;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_out    = 0;
    int    addr_m   = 0;
    int    errcnt_m = 0;
    bit    last_in_hs;
    word_t q[$];
    word_t cur;

    inst_encode #(.ADDR_W(8), .ERRCNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .out_addr  (out_addr),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sext(input logic [31:0] v, input int w);
        longint u;
        u = longint'(v) % (longint'(1) << w);
        if (u >= (longint'(1) << (w - 1))) u = u - (longint'(1) << w);
        return u[31:0];
    endfunction

    function automatic bit exp_err(input word_t w);
        longint s;
        s = longint'($signed(w.imm));
        case (w.op)
            OP_C:            return 1'b0;
            BRANCH_C:        return (s < -4096) || (s > 4095) || (w.imm % 2 != 0);
            JAL_C:           return (s < -(longint'(1) << 20)) || (s >= (longint'(1) << 20))
                                    || (w.imm % 2 != 0);
            LUI_C, AUIPC_C:  return (w.imm % 4096) != 0;
            SYSTEM_C:        return w.imm > 32'd4095;
            default:         return (s < -2048) || (s > 2047);
        endcase
    endfunction

    // Key layout: {op, rd, rs1, rs2, f3, f7, imm}; fields a format does not carry are zero.
    function automatic logic [63:0] exp_key(input word_t w);
        logic [4:0]  k_rd;
        logic [4:0]  k_rs1;
        logic [4:0]  k_rs2;
        logic [2:0]  k_f3;
        logic [6:0]  k_f7;
        logic [31:0] k_imm;
        k_rd = 0; k_rs1 = 0; k_rs2 = 0; k_f3 = 0; k_f7 = 0; k_imm = 0;
        case (w.op)
            OP_C:     begin k_rd = w.rd; k_rs1 = w.rs1; k_rs2 = w.rs2; k_f3 = w.f3; k_f7 = w.f7; end
            STORE_C:  begin k_rs1 = w.rs1; k_rs2 = w.rs2; k_f3 = w.f3; k_imm = sext(w.imm, 12); end
            BRANCH_C: begin
                k_rs1 = w.rs1; k_rs2 = w.rs2; k_f3 = w.f3;
                k_imm = sext(w.imm, 13) & ~32'd1;
            end
            JAL_C:    begin k_rd = w.rd; k_imm = sext(w.imm, 21) & ~32'd1; end
            LUI_C, AUIPC_C: begin k_rd = w.rd; k_imm = w.imm - (w.imm % 4096); end
            default:  begin k_rd = w.rd; k_rs1 = w.rs1; k_f3 = w.f3; k_imm = sext(w.imm, 12); end
        endcase
        return {w.op, k_rd, k_rs1, k_rs2, k_f3, k_f7, k_imm};
    endfunction

    function automatic logic [63:0] dec_key(input logic [31:0] i);
        logic [4:0]  k_rd;
        logic [4:0]  k_rs1;
        logic [4:0]  k_rs2;
        logic [2:0]  k_f3;
        logic [6:0]  k_f7;
        logic [31:0] k_imm;
        k_rd = 0; k_rs1 = 0; k_rs2 = 0; k_f3 = 0; k_f7 = 0; k_imm = 0;
        case (i[6:0])
            OP_C:     begin
                k_rd = i[11:7]; k_rs1 = i[19:15]; k_rs2 = i[24:20]; k_f3 = i[14:12];
                k_f7 = i[31:25];
            end
            STORE_C:  begin
                k_rs1 = i[19:15]; k_rs2 = i[24:20]; k_f3 = i[14:12];
                k_imm = {{20{i[31]}}, i[31:25], i[11:7]};
            end
            BRANCH_C: begin
                k_rs1 = i[19:15]; k_rs2 = i[24:20]; k_f3 = i[14:12];
                k_imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            end
            JAL_C:    begin
                k_rd = i[11:7];
                k_imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            end
            LUI_C, AUIPC_C: begin k_rd = i[11:7]; k_imm = {i[31:12], 12'b0}; end
            default:  begin
                k_rd = i[11:7]; k_rs1 = i[19:15]; k_f3 = i[14:12];
                k_imm = {{20{i[31]}}, i[31:20]};
            end
        endcase
        return {i[6:0], k_rd, k_rs1, k_rs2, k_f3, k_f7, k_imm};
    endfunction

    function automatic word_t mk(input logic [6:0] op, input logic [4:0] a_rd,
                                 input logic [4:0] a_rs1, input logic [4:0] a_rs2,
                                 input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] a_imm, input logic [31:0] hex);
        word_t w;
        w.op = op; w.rd = a_rd; w.rs1 = a_rs1; w.rs2 = a_rs2; w.f3 = f3; w.f7 = f7;
        w.imm = a_imm; w.has_hex = 1'b1; w.hex = hex;
        return w;
    endfunction

    function automatic word_t rand_word();
        word_t w;
        case ($urandom_range(0, 10))
            0: w.op = LUI_C;     1: w.op = AUIPC_C;  2: w.op = JAL_C;   3: w.op = JALR_C;
            4: w.op = BRANCH_C;  5: w.op = LOAD_C;   6: w.op = STORE_C; 7: w.op = OP_IMM_C;
            8: w.op = OP_C;      9: w.op = SYSTEM_C; default: w.op = 7'h0B;
        endcase
        w.rd = 5'($urandom); w.rs1 = 5'($urandom); w.rs2 = 5'($urandom);
        w.f3 = 3'($urandom); w.f7 = 7'($urandom);
        case ($urandom_range(0, 3))
            0: w.imm = 32'($urandom_range(0, 4400)) - 32'd2200;
            1: w.imm = $urandom;
            2: w.imm = $urandom & 32'hFFFFF000;
            default: w.imm = 32'($urandom_range(0, 32'h400000)) - 32'h200000;
        endcase
        w.has_hex = 1'b0; w.hex = '0;
        return w;
    endfunction

    task automatic apply();
        opcode = cur.op; rd = cur.rd; rs1 = cur.rs1; rs2 = cur.rs2;
        funct3 = cur.f3; funct7 = cur.f7; imm = cur.imm;
    endtask

    // One clock: check outputs on the falling edge, update the model, then cross the rising edge.
    task automatic step();
        bit in_hs;
        bit out_hs;
        apply();
        @(negedge clk);
        last_in_hs = 1'b0;
        if (!reset) begin
            chk("in_ready", in_ready, q.size() < 2);
            chk("out_valid", out_valid, q.size() > 0);
            chk("out_addr", out_addr, addr_m % 256);
            chk("err_count", err_count, errcnt_m);
            if (q.size() > 0) begin
                chk("word_err", out_err, exp_err(q[0]));
                chk("word_fields", dec_key(out_inst), exp_key(q[0]));
                if (q[0].has_hex) chk("word_hex", out_inst, q[0].hex);
            end
            in_hs  = in_valid && (q.size() < 2);
            out_hs = out_ready && (q.size() > 0);
            if (out_hs) begin
                if (exp_err(q[0]) && errcnt_m < 255) errcnt_m++;
                addr_m++;
                n_out++;
                void'(q.pop_front());
            end
            if (in_hs) q.push_back(cur);
            last_in_hs = in_hs;
        end
        @(posedge clk);
        #1;
        if (reset) begin
            q.delete();
            addr_m   = 0;
            errcnt_m = 0;
        end
    endtask

    task automatic send(input word_t w);
        bit acc;
        cur = w;
        in_valid = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (last_in_hs) begin
                acc = 1'b1;
                break;
            end
        end
        chk("send_accept", acc, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (q.size() == 0) break;
            step();
        end
        chk("drain_empty", q.size() == 0, 1'b1);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        cur = mk(OP_IMM_C, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
        reset = 1'b0;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_inst", out_inst, 32'h0);
        chk("rst_out_err", out_err, 1'b0);
        chk("rst_out_addr", out_addr, 8'h0);
        chk("rst_err_count", err_count, 8'h0);

        // Directed encodings, streamed back to back.
        out_ready = 1'b1;
        send(mk(OP_IMM_C, 1, 0, 0, 0, 0, 32'd5, 32'h00500093));
        send(mk(STORE_C, 0, 1, 2, 2, 0, 32'd8, 32'h0020A423));
        send(mk(BRANCH_C, 0, 0, 0, 0, 0, 32'hFFFFFFFC, 32'hFE000EE3));
        send(mk(JAL_C, 1, 0, 0, 0, 0, 32'h800, 32'h001000EF));
        send(mk(LUI_C, 5, 0, 0, 0, 0, 32'h12345000, 32'h123452B7));
        send(mk(OP_IMM_C, 1, 0, 0, 0, 0, 32'd2048, 32'h80000093));
        drain();
        chk("err_after_2048", err_count, 8'd1);
        send(mk(BRANCH_C, 0, 0, 0, 0, 0, 32'd3, 32'h00000163));
        send(mk(OP_C, 3, 1, 2, 0, 7'h20, 32'hDEADBEEF, 32'h402081B3));
        drain();
        chk("err_after_b3", err_count, 8'd2);

        // Backpressure from a fresh address.
        reset = 1'b1; step(); reset = 1'b0;
        out_ready = 1'b0;
        send(mk(OP_IMM_C, 2, 3, 0, 1, 0, 32'd7, 32'h00719113));
        send(mk(LOAD_C, 4, 5, 0, 2, 0, 32'hFFFFFFF0, 32'hFF02A203));
        cur = mk(AUIPC_C, 6, 0, 0, 0, 0, 32'hABCDE000, 32'hABCDE317);
        in_valid = 1'b1;
        repeat (3) step();
        chk("bp_in_ready_low", in_ready, 1'b0);
        chk("bp_addr_stall", out_addr, 8'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 20 && !last_in_hs; k++) step();
        chk("bp_third_accepted", last_in_hs, 1'b1);
        drain();
        chk("bp_addr_after", out_addr, 8'd3);

        // Random traffic with random stalls.
        for (int k = 0; k < 600; k++) begin
            cur = rand_word();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        out_ready = 1'b1;
        drain();

        // Errored words to saturate the counter and carry the address through its wrap.
        in_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            cur = mk(OP_IMM_C, 5'($urandom), 5'($urandom), 0, 3'($urandom), 0,
                     32'h00010000 | ($urandom & 32'h0000FFFF), 32'h0);
            cur.has_hex = 1'b0;
            step();
        end
        drain();
        chk("err_saturated", err_count, 8'hFF);
        chk("addr_wrapped", n_out > 300, 1'b1);

        // Reset with both entries full.
        out_ready = 1'b0;
        send(rand_word());
        send(rand_word());
        step();
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_out_valid", out_valid, 1'b1);
        reset = 1'b1; step(); reset = 1'b0;
        chk("post_rst_out_valid", out_valid, 1'b0);
        chk("post_rst_in_ready", in_ready, 1'b1);
        chk("post_rst_addr", out_addr, 8'd0);
        chk("post_rst_err_count", err_count, 8'd0);
        out_ready = 1'b1;
        send(mk(LUI_C, 5, 0, 0, 0, 0, 32'h12345000, 32'h123452B7));
        drain();
        chk("post_rst_addr_next", out_addr, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
